// File: rtl/reg_wb_arbiter_if.sv
// Write-back request/response bundle between the ALU/load units, issue logic and
// the register-file write-back arbiter.
interface reg_wb_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  i_alu_valid;
  logic [REG_ADDR_W-1:0] i_alu_rd;
  logic [DATA_W-1:0]     i_alu_data;
  logic                  o_alu_ready;
  logic                  i_mem_valid;
  logic [REG_ADDR_W-1:0] i_mem_rd;
  logic [DATA_W-1:0]     i_mem_data;
  logic                  o_mem_ready;
  logic                  i_issue_en;
  logic [REG_ADDR_W-1:0] i_issue_rd;
  logic [REG_ADDR_W-1:0] i_chk_rs0;
  logic [REG_ADDR_W-1:0] i_chk_rs1;
  logic                  o_rs0_busy;
  logic                  o_rs1_busy;
  logic                  o_wr_en;
  logic [REG_ADDR_W-1:0] o_wr_reg;
  logic [DATA_W-1:0]     o_wr_data;
  logic                  o_idle;

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_mem_valid, i_mem_rd, i_mem_data,
    input  i_issue_en, i_issue_rd, i_chk_rs0, i_chk_rs1,
    output o_alu_ready, o_mem_ready, o_rs0_busy, o_rs1_busy,
    output o_wr_en, o_wr_reg, o_wr_data, o_idle
  );

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_mem_valid, i_mem_rd, i_mem_data,
    output i_issue_en, i_issue_rd, i_chk_rs0, i_chk_rs1,
    input  o_alu_ready, o_mem_ready, o_rs0_busy, o_rs1_busy,
    input  o_wr_en, o_wr_reg, o_wr_data, o_idle
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter between ALU and load unit with a registered
// register-file write port and a pending-write scoreboard for hazard checks.
module reg_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_N      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  reg_wb_arbiter_if.slave      bus
);

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  logic                  last_grant_q, last_grant_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [REG_N-1:0]      pending_q, pending_d;
  logic                  alu_take, mem_take, contention;

  // Register 0 is hardwired and indices beyond REG_N have no tracking bit.
  function automatic logic reg_ok(input logic [REG_ADDR_W-1:0] r);
    return (int'(r) < REG_N) && (r != '0);
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    contention   = bus.i_alu_valid && bus.i_mem_valid;
    // Under contention the side that lost the previous contention wins.
    alu_take     = i_rst_n && bus.i_alu_valid &&
                   (!bus.i_mem_valid || last_grant_q == GRANT_MEM);
    mem_take     = i_rst_n && bus.i_mem_valid &&
                   (!bus.i_alu_valid || last_grant_q == GRANT_ALU);

    last_grant_d = last_grant_q;
    if (contention) last_grant_d = alu_take ? GRANT_ALU : GRANT_MEM;

    // rd = 0 is accepted but produces no write; reg/data keep their old values.
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (alu_take && bus.i_alu_rd != '0) begin
      wr_en_d   = 1'b1;
      wr_reg_d  = bus.i_alu_rd;
      wr_data_d = bus.i_alu_data;
    end else if (mem_take && bus.i_mem_rd != '0) begin
      wr_en_d   = 1'b1;
      wr_reg_d  = bus.i_mem_rd;
      wr_data_d = bus.i_mem_data;
    end

    // Set is applied after clear so a same-edge issue to the retiring reg wins.
    pending_d = pending_q;
    if (wr_en_q && reg_ok(wr_reg_q)) pending_d[wr_reg_q] = 1'b0;
    if (bus.i_issue_en && reg_ok(bus.i_issue_rd)) pending_d[bus.i_issue_rd] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant_q <= GRANT_MEM;
      wr_en_q      <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      // NOTE: the pending vector is reset as a whole; it is hazard state, not RAM.
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.o_alu_ready = alu_take;
  assign bus.o_mem_ready = mem_take;
  assign bus.o_wr_en     = wr_en_q;
  assign bus.o_wr_reg    = wr_reg_q;
  assign bus.o_wr_data   = wr_data_q;
  assign bus.o_rs0_busy  = reg_ok(bus.i_chk_rs0) && pending_q[bus.i_chk_rs0];
  assign bus.o_rs1_busy  = reg_ok(bus.i_chk_rs1) && pending_q[bus.i_chk_rs1];
  assign bus.o_idle      = (pending_q == '0) && !wr_en_q;

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, write-back data width.
REQ-002 SHALL have parameter REG_N, default 32, number of architectural registers.
REQ-003 SHALL have parameter REG_ADDR_W, default 5, register index width.
REQ-004 SHALL have port i_clk input 1, clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n input 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports i_alu_valid input 1, i_alu_rd input REG_ADDR_W, i_alu_data input DATA_W: ALU write-back request.
REQ-007 SHALL have port o_alu_ready output 1, ALU request accepted this cycle.
REQ-008 SHALL have ports i_mem_valid input 1, i_mem_rd input REG_ADDR_W, i_mem_data input DATA_W: load-unit write-back request.
REQ-009 SHALL have port o_mem_ready output 1, load request accepted this cycle.
REQ-010 SHALL have ports i_issue_en input 1, i_issue_rd input REG_ADDR_W: an issued instruction will write i_issue_rd.
REQ-011 SHALL have ports i_chk_rs0, i_chk_rs1 input REG_ADDR_W: source registers to check.
REQ-012 SHALL have ports o_rs0_busy, o_rs1_busy output 1: source has a pending write.
REQ-013 SHALL have ports o_wr_en output 1, o_wr_reg output REG_ADDR_W, o_wr_data output DATA_W: register-file write port drive.
REQ-014 SHALL have port o_idle output 1, high when no pending bit set and o_wr_en low.

Function
REQ-015 SHALL accept a request only in a cycle where valid and ready are both high; ready SHALL be combinational from valids and grant state.
REQ-016 SHALL accept at most one request per cycle; only one of o_alu_ready, o_mem_ready high per cycle.
REQ-017 SHALL grant the sole valid requester when only one is valid.
REQ-018 SHALL, when both valid, grant the requester not granted at the previous contention (round-robin); 1-bit last_grant updates only on contention cycles.
REQ-019 SHALL require a non-granted requester to hold valid, rd and data stable; the block keeps no internal copy.
REQ-020 SHALL register the accepted request: o_wr_en/o_wr_reg/o_wr_data valid the cycle after acceptance (latency 1), with o_wr_en high exactly one cycle per accept.
REQ-021 SHALL accept requests with rd = 0 but keep o_wr_en low for them; o_wr_reg/o_wr_data hold previous values.
REQ-022 SHALL keep a REG_N-bit pending vector; i_issue_en sets pending[i_issue_rd] at the next edge; rd = 0 never set.
REQ-023 SHALL clear pending[o_wr_reg] at the edge ending a cycle with o_wr_en high.
REQ-024 SHALL, on same-edge set and clear of the same register, leave the bit set.
REQ-025 SHALL drive o_rs0_busy = pending[i_chk_rs0], o_rs1_busy = pending[i_chk_rs1] combinationally, including during the o_wr_en cycle; index 0 always not busy.
REQ-026 SHALL not stall acceptance based on pending state; a write to a non-pending register is legal and clears nothing.

Reset
REQ-027 SHALL, while i_rst_n low, force o_wr_en=0, o_wr_reg=0, o_wr_data=0, pending=0, last_grant=MEM (ALU wins first contention).
REQ-028 SHALL drive o_alu_ready=0, o_mem_ready=0 while i_rst_n low; o_idle=1 after reset.
REQ-029 SHALL discard any registered in-flight write on reset mid-operation; no o_wr_en pulse follows reset release without a new accept.

Verification
REQ-030 Single: ALU valid rd=3 data=0xDEADBEEF -> o_alu_ready same cycle; next cycle o_wr_en=1, reg 3, 0xDEADBEEF; then o_wr_en=0.
REQ-031 Contention: both valid 3 cycles (ALU rd=1, MEM rd=2, held until accepted, re-presented rd=4/5) -> grants ALU, MEM, ALU; o_wr_reg 1,2,4 on cycles 2-4.
REQ-032 Scoreboard: issue rd=7, check rs0=7 -> busy next cycle; MEM write rd=7 -> busy during o_wr_en cycle, clear after.
REQ-033 Collision: pending[9] set, o_wr_en for reg 9 and i_issue_en rd=9 same cycle -> pending[9] remains 1.
REQ-034 Zero reg: ALU rd=0 data=0x1234 -> o_alu_ready=1, o_wr_en stays 0; issue rd=0 -> o_rs0_busy for rs0=0 stays 0.
REQ-035 Reset mid-op: accept rd=5, assert i_rst_n low before next edge -> o_wr_en never pulses, pending=0, o_idle=1.
